// File: rtl/poly_driver.sv
// poly_driver: sequences one operand set {a, b, c, x} onto a poly_calc
// data_in/go pin pair, waits out the compute phase, and returns the
// calculator's result over a valid/ready response port.
module poly_driver #(
  parameter int HOLD_CYCLES = 2,  // go high per operand, 1..255
  parameter int GAP_CYCLES  = 2,  // go low after each release, 1..255
  parameter int CALC_CYCLES = 6   // wait before sampling the result, 4..255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_req_a,
  input  logic [7:0] i_req_b,
  input  logic [7:0] i_req_c,
  input  logic [7:0] i_req_x,
  output logic       o_go,
  output logic [7:0] o_data_out,
  input  logic [7:0] i_calc_result,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic [7:0] o_resp_result,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DRIVE = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Counters hold "cycles remaining minus one" so the state ends when the
  // counter reads zero; each entry reloads it, so it never wraps.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] CALC_RELOAD = 8'(CALC_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [1:0] r_idx, w_idx_next, w_idx_inc;
  logic [7:0] r_cnt, w_cnt_next;
  logic [7:0] r_op [4];
  logic       w_op_load;
  logic       r_go, w_go_next;
  logic [7:0] r_data, w_data_next;
  logic       r_resp_valid, w_resp_valid_next;
  logic [7:0] r_resp_result, w_resp_result_next;

  assign w_idx_inc     = r_idx + 2'd1;
  assign o_req_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_go          = r_go;
  assign o_data_out    = r_data;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_result = r_resp_result;

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so go/data_out leave the block straight from flops.
  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_cnt_next         = r_cnt;
    w_op_load          = 1'b0;
    w_go_next          = 1'b0;
    w_data_next        = r_data;
    w_resp_valid_next  = r_resp_valid;
    w_resp_result_next = r_resp_result;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next = S_SETUP;
          w_op_load    = 1'b1;
          w_idx_next   = 2'd0;
          w_cnt_next   = 8'd0;
          w_data_next  = i_req_a;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_next = S_DRIVE;
        w_cnt_next   = HOLD_RELOAD;
        w_go_next    = 1'b1;
      end
      S_DRIVE: begin
        if (r_cnt == 8'd0) begin
          w_state_next = S_GAP;
          w_cnt_next   = GAP_RELOAD;
          w_go_next    = 1'b0;
        end else begin
          w_cnt_next   = r_cnt - 8'd1;
          w_go_next    = 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt != 8'd0) begin
          w_cnt_next = r_cnt - 8'd1;
        end else if (r_idx != 2'd3) begin
          // Next operand is presented during SETUP, a cycle before go rises.
          w_state_next = S_SETUP;
          w_idx_next   = w_idx_inc;
          w_cnt_next   = 8'd0;
          w_data_next  = r_op[w_idx_inc];
        end else begin
          w_state_next = S_WAIT;
          w_cnt_next   = CALC_RELOAD;
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_next       = S_RESP;
          w_cnt_next         = 8'd0;
          w_resp_valid_next  = 1'b1;
          w_resp_result_next = i_calc_result;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_state_next      = S_IDLE;
          w_resp_valid_next = 1'b0;
        end else begin
          w_state_next = S_RESP;
        end
      end
      default: begin
        w_state_next      = S_IDLE;
        w_idx_next        = 2'd0;
        w_cnt_next        = 8'd0;
        w_data_next       = 8'h00;
        w_resp_valid_next = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset aborts any run in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= 8'd0;
      r_go          <= 1'b0;
      r_data        <= 8'h00;
      r_resp_valid  <= 1'b0;
      r_resp_result <= 8'h00;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_cnt         <= w_cnt_next;
      r_go          <= w_go_next;
      r_data        <= w_data_next;
      r_resp_valid  <= w_resp_valid_next;
      r_resp_result <= w_resp_result_next;
    end
  end

  // Operand latch, loaded only on the accept edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) r_op[i] <= 8'h00;
    end else if (w_op_load) begin
      r_op[0] <= i_req_a;
      r_op[1] <= i_req_b;
      r_op[2] <= i_req_c;
      r_op[3] <= i_req_x;
    end else begin
      for (int i = 0; i < 4; i++) r_op[i] <= r_op[i];
    end
  end

endmodule

// File: tb/tb_poly_driver.sv
// Self-checking bench for poly_driver: two instances (default timing and
// HOLD=1/GAP=1/CALC=4), each attached to a behavioural poly_calc stand-in.
module tb_poly_driver;

  localparam int HOLD_P [2] = '{2, 1};
  localparam int GAP_P  [2] = '{2, 1};
  localparam int CALC_P [2] = '{6, 4};

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid [2];
  logic       req_ready [2];
  logic [7:0] req_a [2], req_b [2], req_c [2], req_x [2];
  logic       go [2];
  logic [7:0] data_out [2];
  logic [7:0] calc_result [2];
  logic       resp_valid [2];
  logic       resp_ready [2];
  logic [7:0] resp_result [2];
  logic       busy [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    poly_driver #(
      .HOLD_CYCLES(HOLD_P[g]), .GAP_CYCLES(GAP_P[g]), .CALC_CYCLES(CALC_P[g])
    ) u_dut (
      .i_clk(clk), .i_reset(reset),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_req_a(req_a[g]), .i_req_b(req_b[g]), .i_req_c(req_c[g]), .i_req_x(req_x[g]),
      .o_go(go[g]), .o_data_out(data_out[g]), .i_calc_result(calc_result[g]),
      .o_resp_valid(resp_valid[g]), .i_resp_ready(resp_ready[g]),
      .o_resp_result(resp_result[g]), .o_busy(busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / calculator stand-in state.
  bit         acc_s [2]     = '{0, 0};
  bit         timing [2]    = '{0, 0};
  int         lat [2]       = '{0, 0};
  int         lat_meas [2]  = '{-1, -1};
  logic       go_prev [2]   = '{1'b0, 1'b0};
  logic [7:0] data_prev [2] = '{8'h00, 8'h00};
  logic [7:0] cur_val [2]   = '{8'h00, 8'h00};
  int         rise_cnt [2]  = '{0, 0};
  int         pulse_cnt [2] = '{0, 0};
  int         run_len [2]   = '{0, 0};
  int         seq_err [2]   = '{0, 0};
  logic [7:0] pulse_val [2][8];
  int         pulse_len [2][8];
  logic [7:0] st_op [2][4];
  int         st_n [2]      = '{0, 0};
  int         st_timer [2]  = '{0, 0};

  // Flag the accept edge (valid & ready seen at a rising edge).
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) acc_s[u] <= !reset && req_valid[u] && req_ready[u];
  end

  // Pin monitor and poly_calc model: loads an operand on each go rise and,
  // shortly after the fourth release, presents b*x^2 + a*x + c mod 256.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        st_n[u] = 0; st_timer[u] = 0; calc_result[u] = 8'hA5; timing[u] = 1'b0;
      end else if (acc_s[u]) begin
        lat[u] = 1; timing[u] = 1'b1; lat_meas[u] = -1;
        rise_cnt[u] = 0; pulse_cnt[u] = 0; run_len[u] = 0; seq_err[u] = 0;
        st_n[u] = 0; st_timer[u] = 0; calc_result[u] = 8'h5A;
      end else begin
        if (timing[u]) begin
          lat[u]++;
          if (resp_valid[u]) begin lat_meas[u] = lat[u]; timing[u] = 1'b0; end
        end
        if (go[u] && !go_prev[u]) begin
          rise_cnt[u]++;
          if (data_out[u] !== data_prev[u]) seq_err[u]++;  // must be set up a cycle early
          if (st_n[u] < 4) st_op[u][st_n[u]] = data_out[u];
          st_n[u]++;
        end
        if (go[u]) begin
          if (run_len[u] == 0) cur_val[u] = data_out[u];
          else if (data_out[u] !== cur_val[u]) seq_err[u]++;
          run_len[u]++;
        end
        if (!go[u] && go_prev[u]) begin
          if (pulse_cnt[u] < 8) begin
            pulse_val[u][pulse_cnt[u]] = cur_val[u];
            pulse_len[u][pulse_cnt[u]] = run_len[u];
          end
          pulse_cnt[u]++;
          run_len[u] = 0;
          if (st_n[u] == 4) st_timer[u] = 2;
        end
        if (st_timer[u] > 0) begin
          st_timer[u]--;
          if (st_timer[u] == 0)
            calc_result[u] = 8'(int'(st_op[u][1]) * int'(st_op[u][3]) * int'(st_op[u][3])
                                + int'(st_op[u][0]) * int'(st_op[u][3]) + int'(st_op[u][2]));
        end
      end
      go_prev[u]   = go[u];
      data_prev[u] = data_out[u];
    end
  end

  // One full transaction on instance u, with bp cycles of response backpressure.
  task automatic run_req(input int u, input logic [7:0] a, b, c, x,
                         input logic [7:0] exp, input int bp);
    logic [7:0] ops [4];
    int lat_exp;
    bit got;
    ops = '{a, b, c, x};
    lat_exp = 4 * (1 + HOLD_P[u] + GAP_P[u]) + CALC_P[u] + 1;
    @(negedge clk); #1;
    check("ready_before_req", req_ready[u], 1);
    req_valid[u] = 1'b1; req_a[u] = a; req_b[u] = b; req_c[u] = c; req_x[u] = x;
    @(negedge clk); #1;
    req_valid[u] = 1'b0;
    check("busy_after_accept", busy[u], 1);
    check("ready_after_accept", req_ready[u], 0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      if (resp_valid[u]) begin
        got = 1'b1; resp_ready[u] = 1'b0; req_valid[u] = 1'b0;
      end else begin
        // Spurious request and response-ready traffic must be ignored.
        resp_ready[u] = 1'($urandom_range(0, 1));
        req_valid[u]  = 1'($urandom_range(0, 1));
        req_a[u] = 8'($urandom); req_b[u] = 8'($urandom);
        req_c[u] = 8'($urandom); req_x[u] = 8'($urandom);
      end
    end
    check("resp_timeout", got, 1);
    check("resp_result", resp_result[u], exp);
    check("latency", lat_meas[u], lat_exp);
    check("go_pulses", pulse_cnt[u], 4);
    check("data_setup_hold", seq_err[u], 0);
    for (int p = 0; p < 4; p++) begin
      check("pulse_len", pulse_len[u][p], HOLD_P[u]);
      check("pulse_data", pulse_val[u][p], ops[p]);
    end
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); #1;
      check("bp_valid", resp_valid[u], 1);
      check("bp_result", resp_result[u], exp);
      check("bp_ready", req_ready[u], 0);
      check("bp_go", go[u], 0);
    end
    resp_ready[u] = 1'b1;
    @(negedge clk); #1;
    resp_ready[u] = 1'b0;
    check("valid_cleared", resp_valid[u], 0);
    check("idle_ready", req_ready[u], 1);
    check("idle_busy", busy[u], 0);
  endtask

  // Reset pulse during the second go pulse, then a fresh transaction.
  task automatic reset_mid();
    bit found;
    @(negedge clk); #1;
    req_valid[0] = 1'b1; req_a[0] = 8'd1; req_b[0] = 8'd2; req_c[0] = 8'd3; req_x[0] = 8'd4;
    @(negedge clk); #1;
    req_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (go[0] && rise_cnt[0] == 2) found = 1'b1;
    end
    check("second_drive_seen", found, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst_go", go[0], 0);
    check("rst_data", data_out[0], 8'h00);
    check("rst_ready", req_ready[0], 1);
    check("rst_resp_valid", resp_valid[0], 0);
    check("rst_busy", busy[0], 0);
    run_req(0, 8'd5, 8'd0, 8'd7, 8'd2, 8'h11, 0);
  endtask

  initial begin
    logic [7:0] a, b, c, x;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; resp_ready[u] = 1'b0;
      req_a[u] = 8'h00; req_b[u] = 8'h00; req_c[u] = 8'h00; req_x[u] = 8'h00;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_go", go[u], 0);
      check("reset_data", data_out[u], 8'h00);
      check("reset_resp_valid", resp_valid[u], 0);
      check("reset_resp_result", resp_result[u], 8'h00);
      check("reset_ready", req_ready[u], 1);
      check("reset_busy", busy[u], 0);
    end
    reset = 1'b0;

    run_req(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h27, 0);
    run_req(0, 8'h00, 8'h10, 8'h01, 8'h10, 8'h01, 0);
    run_req(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h27, 10);
    run_req(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    reset_mid();
    run_req(1, 8'd3, 8'd1, 8'd2, 8'd5, 8'h2A, 0);

    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
      run_req(n % 2, a, b, c, x,
              8'(int'(b) * int'(x) * int'(x) + int'(a) * int'(x) + int'(c)),
              int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
